// File: rtl/out_signature_misr_pkg.sv
// Shared types and the MISR step function for the output-signature checker.
package sig_pkg;

    typedef enum logic [1:0] {
        WARMUP  = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
    localparam int          MAX_W        = 64;
    localparam int          IDXW         = $clog2(MAX_W);

    // One MISR step for a w-bit register held in the low bits of a MAX_W vector.
    function automatic logic [MAX_W-1:0] misr_next(input logic [MAX_W-1:0] sig,
                                                   input logic [MAX_W-1:0] in,
                                                   input logic [MAX_W-1:0] poly,
                                                   input int w);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] fb;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        fb   = sig[IDXW'(w - 1)] ? poly : '0;
        return (((sig << 1) & mask) ^ fb ^ in) & mask;
    endfunction

endpackage

// File: rtl/out_signature_misr_misr_reg.sv
// Signature register: synchronous clear to SEED, one MISR step per enabled cycle.
module misr_reg
    import sig_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] SEED  = '0,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY)
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] sig_o,
    output logic [WIDTH-1:0] sig_next_o
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    assign sig_d = WIDTH'(misr_next(MAX_W'(sig_q), MAX_W'(data_i), MAX_W'(POLY), WIDTH));

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            sig_q <= SEED;
        end else if (en_i) begin
            sig_q <= sig_d;
        end
    end

    assign sig_o      = sig_q;
    assign sig_next_o = sig_d;

endmodule

// File: rtl/out_signature_misr.sv
// Output-signature checker: skips pipeline fill, compacts WINDOW samples, then freezes
// with a registered pass/fail against EXPECTED.
module out_signature_misr
    import sig_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               SKIP     = 2,
    parameter int               WINDOW   = 256,
    parameter logic [WIDTH-1:0] SEED     = '0,
    parameter logic [WIDTH-1:0] POLY     = WIDTH'(DEFAULT_POLY),
    parameter logic [WIDTH-1:0] EXPECTED = '0,
    localparam int              CNTW     = $clog2(((SKIP > WINDOW) ? SKIP : WINDOW) + 1) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             hold,
    output logic [WIDTH-1:0] signature,
    output logic [CNTW-1:0]  sample_cnt,
    output logic             busy,
    output logic             done,
    output logic             match
);

    localparam logic [CNTW-1:0] SKIP_C      = CNTW'(SKIP);
    localparam logic [CNTW-1:0] LAST_C      = CNTW'(WINDOW - 1);
    localparam state_t          RESET_STATE = (SKIP == 0) ? CAPTURE : WARMUP;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   skip_q, skip_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              match_q, match_d;
    logic              sig_en;
    logic [WIDTH-1:0]  sig_next;

    misr_reg #(
        .WIDTH (WIDTH),
        .SEED  (SEED),
        .POLY  (POLY)
    ) u_misr (
        .clk_i      (clk),
        .clr_i      (rst),
        .en_i       (sig_en),
        .data_i     (in),
        .sig_o      (signature),
        .sig_next_o (sig_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
            skip_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        match_d = match_q;
        sig_en  = 1'b0;
        unique case (state_q)
            WARMUP: begin
                if (!hold) begin
                    skip_d = skip_q + 1'b1;
                    if (skip_d >= SKIP_C) begin
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (!hold) begin
                    sig_en = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    // match is decided from the value the signature takes on this edge
                    if (cnt_q == LAST_C) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        match_d = (sig_next == EXPECTED);
                    end
                end
            end
            DONE: begin
            end
            default: begin
                state_d = WARMUP;
                skip_d  = '0;
                cnt_d   = '0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                match_d = 1'b0;
            end
        endcase
    end

    assign sample_cnt = cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign match      = match_q;

endmodule

// File: tb/tb_out_signature_misr.sv
// Bench for out_signature_misr: three configurations against a polynomial-sum reference.
module tb_out_signature_misr;

  localparam logic [31:0] P = 32'h04C11DB7;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic [31:0] in_a = '0, in_b = '0, in_c = '0;
  logic        hold_a = 1'b0, hold_b = 1'b0, hold_c = 1'b0;
  logic [31:0] sig_a, sig_b, sig_c;
  logic [1:0]  cnt_a;
  logic [2:0]  cnt_b;
  logic [9:0]  cnt_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        match_a, match_b, match_c;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_aa;

  always #1 clk = ~clk;

  out_signature_misr #(.SKIP(0), .WINDOW(1), .EXPECTED(32'habcdefab)) dut_a (
    .clk(clk), .rst(rst_a), .in(in_a), .hold(hold_a), .signature(sig_a),
    .sample_cnt(cnt_a), .busy(busy_a), .done(done_a), .match(match_a));

  out_signature_misr #(.SKIP(0), .WINDOW(2)) dut_b (
    .clk(clk), .rst(rst_b), .in(in_b), .hold(hold_b), .signature(sig_b),
    .sample_cnt(cnt_b), .busy(busy_b), .done(done_b), .match(match_b));

  out_signature_misr dut_c (
    .clk(clk), .rst(rst_c), .in(in_c), .hold(hold_c), .signature(sig_c),
    .sample_cnt(cnt_c), .busy(busy_c), .done(done_c), .match(match_c));

  // Reference: signature = seed*x^N + sum_k s_k*x^(N-1-k) mod POLY, over GF(2).
  function automatic logic [31:0] mulx(input logic [31:0] v);
    return {v[30:0], 1'b0} ^ (v[31] ? P : 32'h0);
  endfunction

  function automatic logic [31:0] mulx_n(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = mulx(r);
    return r;
  endfunction

  function automatic logic [31:0] ref_sig(input logic [31:0] seed);
    logic [31:0] acc;
    int n;
    n = exp_q.size();
    acc = mulx_n(seed, n);
    for (int k = 0; k < n; k++) acc = acc ^ mulx_n(exp_q[k], n - 1 - k);
    return acc;
  endfunction

  // Reset held for 5 edges (10 time units); released on a falling edge.
  task automatic pulse_reset(input int which);
    @(negedge clk);
    case (which)
      0: rst_a = 1'b1;
      1: rst_b = 1'b1;
      default: rst_c = 1'b1;
    endcase
    repeat (5) @(negedge clk);
    case (which)
      0: rst_a = 1'b0;
      1: rst_b = 1'b0;
      default: rst_c = 1'b0;
    endcase
  endtask

  // Drives dut_c from just after reset release until done; edges=-1 on timeout.
  task automatic c_run(input logic [31:0] data, input int hold_start, input int hold_len,
                       output int edges);
    edges = -1;
    for (int e = 1; e <= 400; e++) begin
      in_c = data;
      hold_c = (e >= hold_start) && (e < hold_start + hold_len);
      @(negedge clk);
      if (done_c === 1'b1) begin
        edges = e;
        break;
      end
    end
    hold_c = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_c = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (sig_c !== 32'h0 || cnt_c !== 10'd0 || busy_c !== 1'b1 || done_c !== 1'b0 ||
        match_c !== 1'b0) begin
      failures++;
      $display("FAIL reset: sig=%h cnt=%0d busy=%b done=%b match=%b, want 0/0/1/0/0",
               sig_c, cnt_c, busy_c, done_c, match_c);
    end
  endtask

  task automatic test_window1();
    in_a = 32'habcdefab;
    hold_a = 1'b0;
    pulse_reset(0);
    @(negedge clk);
    checks++;
    if (sig_a !== 32'habcdefab || cnt_a !== 2'd1 || done_a !== 1'b1 || match_a !== 1'b1 ||
        busy_a !== 1'b0) begin
      failures++;
      $display("FAIL window1: sig=%h cnt=%0d done=%b match=%b busy=%b, want abcdefab/1/1/1/0",
               sig_a, cnt_a, done_a, match_a, busy_a);
    end
  endtask

  task automatic test_last_hold();
    logic [31:0] d;
    d = $urandom;
    in_a = d;
    hold_a = 1'b1;
    pulse_reset(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done_a !== 1'b0 || cnt_a !== 2'd0 || busy_a !== 1'b1 || sig_a !== 32'h0) begin
        failures++;
        $display("FAIL last_hold_defer: done=%b cnt=%0d busy=%b sig=%h, want 0/0/1/0",
                 done_a, cnt_a, busy_a, sig_a);
      end
    end
    hold_a = 1'b0;
    @(negedge clk);
    exp_q.delete();
    exp_q.push_back(d);
    checks++;
    if (sig_a !== ref_sig(32'h0) || done_a !== 1'b1 || match_a !== (d == 32'habcdefab)) begin
      failures++;
      $display("FAIL last_hold_release: sig=%h done=%b match=%b, want %h/1/%b",
               sig_a, done_a, match_a, ref_sig(32'h0), d == 32'habcdefab);
    end
  endtask

  task automatic test_window2();
    in_b = 32'h80000000;
    hold_b = 1'b0;
    pulse_reset(1);
    exp_q.delete();
    exp_q.push_back(32'h80000000);
    @(negedge clk);
    checks++;
    if (sig_b !== ref_sig(32'h0) || cnt_b !== 3'd1 || done_b !== 1'b0 || busy_b !== 1'b1) begin
      failures++;
      $display("FAIL window2_first: sig=%h cnt=%0d done=%b busy=%b, want %h/1/0/1",
               sig_b, cnt_b, done_b, busy_b, ref_sig(32'h0));
    end
    in_b = 32'h0;
    exp_q.push_back(32'h0);
    @(negedge clk);
    checks++;
    if (sig_b !== ref_sig(32'h0) || sig_b !== 32'h04C11DB7 || cnt_b !== 3'd2 ||
        done_b !== 1'b1 || match_b !== 1'b0) begin
      failures++;
      $display("FAIL window2_second: sig=%h cnt=%0d done=%b match=%b, want 04c11db7/2/1/0",
               sig_b, cnt_b, done_b, match_b);
    end
  endtask

  task automatic test_zero_stream();
    int edges;
    pulse_reset(2);
    c_run(32'h0, 0, 0, edges);
    checks++;
    if (edges !== 258 || sig_c !== 32'h0 || cnt_c !== 10'd256 || match_c !== 1'b1 ||
        busy_c !== 1'b0) begin
      failures++;
      $display("FAIL zero_stream: edges=%0d sig=%h cnt=%0d match=%b busy=%b, want 258/0/256/1/0",
               edges, sig_c, cnt_c, match_c, busy_c);
    end
  endtask

  task automatic test_hold_stall();
    int edges;
    int hs;
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(32'haaaaaaaa);
    ref_aa = ref_sig(32'h0);
    pulse_reset(2);
    c_run(32'haaaaaaaa, 0, 0, edges);
    checks++;
    if (edges !== 258 || sig_c !== ref_aa || match_c !== (ref_aa == 32'h0)) begin
      failures++;
      $display("FAIL aa_nohold: edges=%0d sig=%h match=%b, want 258/%h/%b",
               edges, sig_c, match_c, ref_aa, ref_aa == 32'h0);
    end
    hs = $urandom_range(10, 200);
    pulse_reset(2);
    c_run(32'haaaaaaaa, hs, 5, edges);
    checks++;
    if (edges !== 263 || sig_c !== ref_aa || cnt_c !== 10'd256) begin
      failures++;
      $display("FAIL aa_hold5: edges=%0d sig=%h cnt=%0d, want 263/%h/256",
               edges, sig_c, cnt_c, ref_aa);
    end
  endtask

  task automatic test_mid_reset();
    int edges;
    pulse_reset(2);
    in_c = 32'haaaaaaaa;
    hold_c = 1'b0;
    repeat (102) @(negedge clk);
    checks++;
    if (cnt_c !== 10'd100 || done_c !== 1'b0) begin
      failures++;
      $display("FAIL mid_progress: cnt=%0d done=%b, want 100/0", cnt_c, done_c);
    end
    rst_c = 1'b1;
    @(negedge clk);
    rst_c = 1'b0;
    checks++;
    if (sig_c !== 32'h0 || cnt_c !== 10'd0 || done_c !== 1'b0 || busy_c !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: sig=%h cnt=%0d done=%b busy=%b, want 0/0/0/1",
               sig_c, cnt_c, done_c, busy_c);
    end
    c_run(32'haaaaaaaa, 0, 0, edges);
    checks++;
    if (edges !== 258 || sig_c !== ref_aa) begin
      failures++;
      $display("FAIL rerun: edges=%0d sig=%h, want 258/%h", edges, sig_c, ref_aa);
    end
  endtask

  task automatic test_frozen();
    logic exp_match;
    exp_match = (ref_aa == 32'h0);
    for (int i = 0; i < 50; i++) begin
      in_c = 32'h12345678;
      hold_c = i[0];
      @(negedge clk);
      checks++;
      if (sig_c !== ref_aa || cnt_c !== 10'd256 || match_c !== exp_match || done_c !== 1'b1) begin
        failures++;
        $display("FAIL frozen[%0d]: sig=%h cnt=%0d match=%b done=%b, want %h/256/%b/1",
                 i, sig_c, cnt_c, match_c, done_c, ref_aa, exp_match);
      end
    end
    hold_c = 1'b0;
  endtask

  task automatic test_random();
    int nh;
    bit timed_out;
    logic [31:0] r;
    logic [31:0] d;
    logic h;
    exp_q.delete();
    nh = 0;
    timed_out = 1'b1;
    pulse_reset(2);
    for (int cyc = 0; cyc < 1200; cyc++) begin
      d = $urandom;
      h = ($urandom_range(0, 3) == 0);
      in_c = d;
      hold_c = h;
      if (!h) begin
        if (nh < 2) nh++;
        else if (exp_q.size() < 256) exp_q.push_back(d);
      end
      @(negedge clk);
      checks++;
      if (cnt_c !== 10'(exp_q.size()) || done_c !== (exp_q.size() == 256) ||
          busy_c !== (exp_q.size() != 256)) begin
        failures++;
        $display("FAIL random_cycle[%0d]: cnt=%0d done=%b busy=%b, want cnt=%0d",
                 cyc, cnt_c, done_c, busy_c, exp_q.size());
      end
      if (exp_q.size() == 256) begin
        timed_out = 1'b0;
        break;
      end
    end
    hold_c = 1'b0;
    r = ref_sig(32'h0);
    checks++;
    if (timed_out || sig_c !== r || match_c !== (r == 32'h0)) begin
      failures++;
      $display("FAIL random_final: timeout=%b sig=%h match=%b, want %h/%b",
               timed_out, sig_c, match_c, r, r == 32'h0);
    end
  endtask

  initial begin
    repeat (6) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    test_reset();
    test_window1();
    test_last_hold();
    test_window2();
    test_zero_stream();
    test_hold_stall();
    test_mid_reset();
    test_frozen();
    test_random();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
